// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write/status bundle for the boot loader.
// Latency: none (wires only).
// Backpressure: none; the byte stream is strobe-only and writes are fire-and-forget.
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [8:0]  words_loaded;

   // loader side: consumes bytes, produces RAM writes and status
   modport master (
      input  rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, words_loaded
   );

   // environment side: UART receiver, instruction RAM and CPU control
   modport slave (
      output rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Frame parser that assembles big-endian words from UART bytes and writes them into instruction RAM.
// Latency: write strobe one cycle after a word's 4th byte; done/err one cycle after the checksum byte.
// Backpressure: none; every byte is accepted, including one arriving while a write pulse is out.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus
);

   localparam logic [7:0]  SYNC = 8'hA5;
   localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CNT, DATA, CHK} state_t;

   state_t      state;
   logic [1:0]  lane;
   logic [7:0]  idx;
   logic [8:0]  remaining;
   logic [7:0]  csum;
   logic [31:0] word_q;
   logic [31:0] tcnt;

   logic        wr_en_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic        cpu_hold_q;
   logic        load_done_q;
   logic        load_err_q;
   logic [8:0]  words_loaded_q;

   logic [31:0] word_nxt;

   assign word_nxt = {word_q[23:0], bus.rx_data};

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.cpu_hold     = cpu_hold_q;
   assign bus.load_done    = load_done_q;
   assign bus.load_err     = load_err_q;
   assign bus.words_loaded = words_loaded_q;

   // Frame FSM: sync hunt, count, word assembly with writes, checksum verdict, idle timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         lane           <= '0;
         idx            <= '0;
         remaining      <= '0;
         csum           <= '0;
         word_q         <= '0;
         tcnt           <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= BASE_ADDR;
         wr_data_q      <= '0;
         cpu_hold_q     <= 1'b0;
         load_done_q    <= 1'b0;
         load_err_q     <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         // strobes are single-cycle unless re-asserted below
         wr_en_q     <= 1'b0;
         load_done_q <= 1'b0;

         if (state == IDLE) begin
            if (bus.rx_valid && bus.rx_data == SYNC) begin
               state          <= CNT;
               cpu_hold_q     <= 1'b1;
               load_err_q     <= 1'b0;
               words_loaded_q <= '0;
               csum           <= '0;
               lane           <= '0;
               idx            <= '0;
               tcnt           <= '0;
            end
         end else if (bus.rx_valid) begin
            // any byte inside a frame restarts the idle timer
            tcnt <= '0;
            case (state)
               CNT: begin
                  // a count byte of zero encodes a full 256-word image
                  remaining <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                  state     <= DATA;
               end
               DATA: begin
                  word_q <= word_nxt;
                  csum   <= csum ^ bus.rx_data;
                  lane   <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     wr_en_q        <= 1'b1;
                     wr_data_q      <= word_nxt;
                     wr_addr_q      <= BASE_ADDR + {22'd0, idx, 2'b00};
                     idx            <= idx + 8'd1;
                     words_loaded_q <= words_loaded_q + 9'd1;
                     remaining      <= remaining - 9'd1;
                     if (remaining == 9'd1) begin
                        state <= CHK;
                     end
                  end
               end
               CHK: begin
                  if (bus.rx_data == csum) begin
                     load_done_q <= 1'b1;
                  end else begin
                     load_err_q <= 1'b1;
                  end
                  cpu_hold_q <= 1'b0;
                  state      <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (tcnt == TMAX) begin
            // stream went silent mid-frame: abandon it, keep any words already written
            load_err_q <= 1'b1;
            cpu_hold_q <= 1'b0;
            state      <= IDLE;
         end else begin
            tcnt <= tcnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          TO   = 16;

   logic clk;
   logic reset;

   imem_loader_if bus ();

   imem_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic [63:0] wq[$];
   int          done_cnt;

   logic [7:0]  fr[$];
   logic [63:0] exp_q[$];
   int          exp_n;
   bit          exp_ok;

   // capture every write pulse and done pulse half a cycle after the edge
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
      if (bus.load_done === 1'b1) done_cnt++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish (observed hang, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Frame-level reference: parse the byte list into expected writes and verdict.
   task automatic model_frame();
      int n;
      logic [7:0]  cs;
      logic [31:0] w;
      exp_q.delete();
      n  = (fr[1] == 8'h00) ? 256 : int'(fr[1]);
      cs = 8'h00;
      for (int k = 0; k < n; k++) begin
         w = {fr[2+4*k], fr[3+4*k], fr[4+4*k], fr[5+4*k]};
         cs = cs ^ fr[2+4*k] ^ fr[3+4*k] ^ fr[4+4*k] ^ fr[5+4*k];
         exp_q.push_back({BASE + 32'(4*k), w});
      end
      exp_n  = n;
      exp_ok = (fr[2+4*n] == cs);
   endtask

   task automatic send_frame(input string tag, input int gapmax);
      int last;
      model_frame();
      last = fr.size() - 1;
      for (int i = 0; i <= last; i++) begin
         send(fr[i], (i == last) ? 0 : $urandom_range(0, gapmax));
         if (i == 0) chk({tag, "_sync_err_clr"}, 64'(bus.load_err), 64'd0);
         if (i < last) chk({tag, "_hold_in_frame"}, 64'(bus.cpu_hold), 64'd1);
      end
      chk({tag, "_hold_release"}, 64'(bus.cpu_hold), 64'd0);
      chk({tag, "_done_edge"}, 64'(bus.load_done), 64'(exp_ok));
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string tag);
      int m;
      chk({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
      m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk($sformatf("%s_write%0d", tag, i), wq[i], exp_q[i]);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_ok));
      chk({tag, "_err"}, 64'(bus.load_err), 64'(!exp_ok));
      chk({tag, "_hold"}, 64'(bus.cpu_hold), 64'd0);
      chk({tag, "_words"}, 64'(bus.words_loaded), 64'(exp_n));
   endtask

   task automatic clear_obs();
      wq.delete();
      done_cnt = 0;
   endtask

   task automatic good_frame_bytes();
      fr = '{8'hA5, 8'h02, 8'h24, 8'h05, 8'h00, 8'h00, 8'h24, 8'h07, 8'h02, 8'h00, 8'h00};
   endtask

   initial begin
      int cyc;
      logic hold_before;
      int n;
      logic [7:0] b;
      logic [7:0] cs;

      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      done_cnt     = 0;

      // reset: outputs cleared while held, and after release
      repeat (5) @(negedge clk);
      chk("rst_hold_low", 64'(bus.cpu_hold), 64'd0);
      chk("rst_wren_low", 64'(bus.wr_en), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_wr_addr", 64'(bus.wr_addr), 64'(BASE));
      chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
      chk("rst_done", 64'(bus.load_done), 64'd0);
      chk("rst_err", 64'(bus.load_err), 64'd0);
      chk("rst_words", 64'(bus.words_loaded), 64'd0);
      clear_obs();
      repeat (20) @(negedge clk);
      chk("rst_no_writes", 64'(wq.size()), 64'd0);

      // good frame preceded by noise bytes
      clear_obs();
      send(8'h11, 0);
      send(8'h22, 0);
      chk("noise_no_hold", 64'(bus.cpu_hold), 64'd0);
      good_frame_bytes();
      send_frame("good", 0);
      check_frame("good");
      chk("good_w1_const", (wq.size() > 1) ? wq[1] : 64'd0, {32'h0000_0004, 32'h2407_0200});

      // bad checksum: writes still land, error instead of done
      clear_obs();
      good_frame_bytes();
      fr[10] = 8'h01;
      send_frame("badcs", 0);
      check_frame("badcs");

      // a good frame afterwards clears the error on its sync byte
      clear_obs();
      good_frame_bytes();
      send_frame("after_bad", 2);
      check_frame("after_bad");

      // timeout after one partial word
      clear_obs();
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h24, 0);
      send(8'h05, 0);
      send(8'h00, 0);
      cyc = 0;
      hold_before = 1'b0;
      while (bus.load_err !== 1'b1 && cyc < 100) begin
         hold_before = bus.cpu_hold;
         @(negedge clk);
         cyc++;
      end
      chk("to_latency", 64'(cyc), 64'(TO));
      chk("to_hold_before", 64'(hold_before), 64'd1);
      chk("to_hold_after", 64'(bus.cpu_hold), 64'd0);
      chk("to_no_writes", 64'(wq.size()), 64'd0);
      chk("to_words", 64'(bus.words_loaded), 64'd0);

      clear_obs();
      good_frame_bytes();
      send_frame("after_to", 0);
      check_frame("after_to");

      // full-depth frame: 256 words, word k = k, back-to-back bytes
      clear_obs();
      fr.delete();
      fr.push_back(8'hA5);
      fr.push_back(8'h00);
      cs = 8'h00;
      for (int k = 0; k < 256; k++) begin
         fr.push_back(8'h00);
         fr.push_back(8'h00);
         fr.push_back(8'h00);
         fr.push_back(8'(k));
         cs = cs ^ 8'(k);
      end
      fr.push_back(cs);
      send_frame("full", 0);
      check_frame("full");
      chk("full_last_const", (wq.size() == 256) ? wq[255] : 64'd0, {32'h0000_03FC, 32'h0000_00FF});

      // mid-frame reset after two words of a four-word frame
      clear_obs();
      send(8'hA5, 0);
      send(8'h04, 0);
      for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("mrst_hold", 64'(bus.cpu_hold), 64'd0);
      chk("mrst_wren", 64'(bus.wr_en), 64'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) send(8'hA5, 0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("mrst_two_writes", 64'(wq.size()), 64'd2);
      chk("mrst_w1", (wq.size() > 1) ? wq[1] : 64'd0, {32'h0000_0004, 32'h3435_3637});
      chk("mrst_words", 64'(bus.words_loaded), 64'd0);
      chk("mrst_idle_hold", 64'(bus.cpu_hold), 64'd0);

      clear_obs();
      good_frame_bytes();
      send_frame("after_mrst", 0);
      check_frame("after_mrst");

      // randomized frames: random length, data (with embedded sync values), gaps and checksum faults
      for (int r = 0; r < 8; r++) begin
         clear_obs();
         n = $urandom_range(1, 6);
         fr.delete();
         fr.push_back(8'hA5);
         fr.push_back(8'(n));
         cs = 8'h00;
         for (int i = 0; i < 4 * n; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            fr.push_back(b);
            cs = cs ^ b;
         end
         if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
         fr.push_back(cs);
         send_frame($sformatf("rnd%0d", r), 4);
         check_frame($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's instruction memory. It receives a framed byte stream from the UART receiver, assembles big-endian 32-bit words, and issues one write per word into the writable instruction RAM port at consecutive word addresses. It holds the pipeline in reset while a load is in progress. It sits between the UART RX block and the instruction RAM write port, and is the producer side of the instruction fetch path.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap in cycles between bytes inside a frame.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per byte; back-to-back strobes are legal.
- wr_en  out  1  one-cycle instruction RAM write strobe.
- wr_addr  out  32  byte address of the write: BASE_ADDR + 4*index.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  1 while a frame is being loaded; drives the CPU reset/stall.
- load_done  out  1  one-cycle pulse on a successful frame.
- load_err  out  1  level; set on checksum mismatch or timeout, cleared when the next sync byte is accepted.
- words_loaded  out  9  number of words written in the current or last frame.

## Operation
- Frame format: sync 0xA5, count byte N (0 means 256), then N×4 data bytes (MSB first per word), then a checksum byte equal to the XOR of all data bytes. The sync and count bytes are excluded from the checksum.
- States:
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5: go to CNT, set cpu_hold=1, clear load_err, words_loaded, checksum and byte lane.
  - CNT: the next byte loads the remaining-word counter (9 bits, 0→256). Go to DATA.
  - DATA: each byte shifts into the word register (lane 0..3) and XORs into the checksum. On lane 3:
    - Register wr_en=1, wr_data=the assembled word, wr_addr=BASE_ADDR+{index,2'b00} for the next cycle.
    - Increment index and words_loaded.
    - If this was the last word, go to CHK.
  - CHK: on the next byte:
    - Match: load_done=1 for one cycle, cpu_hold=0.
    - Mismatch: load_err=1, cpu_hold=0, no load_done.
    - Either way, go to IDLE.
- Index is 8 bits and wraps at 256. A count of 256 fills addresses BASE_ADDR..BASE_ADDR+0x3FC exactly.
- Inside a frame, 0xA5 is treated as ordinary data.
- Timeout: a counter runs in CNT/DATA/CHK and clears on every rx_valid. When it reaches TIMEOUT_CYCLES-1 without a byte: load_err=1, cpu_hold=0, go to IDLE. No partial word is written.
- There is no rollback. Words written before an error remain in RAM.
- A write pulse never stalls byte acceptance. A byte arriving in the same cycle that wr_en is high is processed normally.

## Timing
- Reset values: wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0, state=IDLE.
- Sync byte strobed at cycle t → cpu_hold=1 at t+1.
- 4th byte of a word strobed at t → wr_en=1 with valid addr/data at t+1 only. wr_addr/wr_data hold their values until the next write.
- Checksum byte at t → load_done (or load_err) and cpu_hold=0 at t+1.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.
- Asserting reset mid-frame forces cpu_hold=0 and wr_en=0 combinationally via the async clear. No further writes occur, and the next frame starts at index 0.
- rx_valid during reset is ignored.

## Test plan
- Reset: hold reset=0 for 5 cycles, then release → all outputs at their reset values, wr_addr=0x0, no wr_en for 20 idle cycles.
- Good frame: send noise bytes 0x11, 0x22, then A5 02 24 05 00 00 24 07 02 00 00 back-to-back.
  - Writes 0x24050000 @0x0 and 0x24070200 @0x4.
  - load_done pulses once, load_err=0, words_loaded=2, cpu_hold high from sync+1 until checksum+1.
- Bad checksum: same frame with final byte 0x01 → both writes still occur, load_err=1, no load_done, cpu_hold=0. A following good frame clears load_err on its sync byte.
- Timeout (TIMEOUT_CYCLES=16): A5 01 24 05 00, then silence → no wr_en, load_err=1 and cpu_hold=0 exactly 16 cycles after byte 0x00. A subsequent full frame loads correctly.
- Full depth: count 0x00, 1024 data bytes with rx_valid every cycle (word k = k) → 256 writes, last at 0x3FC with data 0xFF, no dropped bytes, words_loaded=256, load_done pulses.
- Mid-frame reset: assert reset after 2 words of a 4-word frame → cpu_hold=0 immediately, no further writes. A new frame then writes starting at BASE_ADDR.
